// File: rtl/trap_ctrl_pkg.sv
// Shared types for the trap controller: cause encoding, FSM states and event kinds.
// Vectoring (TRAP_CTRL_VECTORED_EN) uses vec_offset() from here.
package trap_ctrl_pkg;

    typedef struct packed {
        logic        irq;
        logic [30:0] code;
    } mcause_t;

    localparam mcause_t MCAUSE_NONE          = '{irq: 1'b0, code: 31'd0};
    localparam mcause_t MCAUSE_ILLEGAL_INSTR = '{irq: 1'b0, code: 31'd2};
    localparam mcause_t MCAUSE_MSI           = '{irq: 1'b1, code: 31'd3};
    localparam mcause_t MCAUSE_MTI           = '{irq: 1'b1, code: 31'd7};
    localparam mcause_t MCAUSE_MEI           = '{irq: 1'b1, code: 31'd11};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_t;

    typedef enum logic {
        EV_TRAP = 1'b0,
        EV_MRET = 1'b1
    } ev_kind_t;

    // Vector table offset: interrupts land at base + 4*code, exceptions at base.
    function automatic logic [31:0] vec_offset(input mcause_t c);
        return c.irq ? {c.code[29:0], 2'b00} : 32'd0;
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_arb.sv
// Interrupt arbiter: pending qualification by global mie, fixed priority MEI > MSI > MTI.
// Purely combinational, zero latency, no backpressure.
module irq_arb
    import trap_ctrl_pkg::*;
(
    input  logic    i_mie,
    input  logic    i_mtip,
    input  logic    i_msip,
    input  logic    i_meip,
    input  logic    i_mtie,
    input  logic    i_msie,
    input  logic    i_meie,
    output logic    o_irq_pend,
    output mcause_t o_irq_cause
);

    logic w_mei;
    logic w_msi;
    logic w_mti;

    assign w_mei = i_meip & i_meie;
    assign w_msi = i_msip & i_msie;
    assign w_mti = i_mtip & i_mtie;

    assign o_irq_pend = i_mie & (w_mei | w_msi | w_mti);

    always_comb begin
        o_irq_cause = MCAUSE_NONE;
        if (w_mei)      o_irq_cause = MCAUSE_MEI;
        else if (w_msi) o_irq_cause = MCAUSE_MSI;
        else if (w_mti) o_irq_cause = MCAUSE_MTI;
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: latches exception/MRET/interrupt, drains, commits CSRs, redirects.
// Min latency event->redirect strobe 3 cycles; DRAIN stalls indefinitely on !pipe_idle. Macro: TRAP_CTRL_VECTORED_EN.
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_exc_valid,
    input  mcause_t     i_exc_cause,
    input  logic [31:0] i_exc_pc,
    input  logic [31:0] i_exc_tval,
    input  logic        i_mret,
    input  logic [31:0] i_retire_pc,
    input  logic        i_pipe_idle,
    input  logic        i_mtip,
    input  logic        i_msip,
    input  logic        i_meip,
    input  logic        i_mtie,
    input  logic        i_msie,
    input  logic        i_meie,
    input  logic [29:0] i_mtvec_base,
    input  logic        i_csr_we,
    input  logic        i_mie_wd,
    input  logic        i_mpie_wd,
    input  logic [31:0] i_mepc_wd,
    input  logic [31:0] i_mtval_wd,
    input  mcause_t     i_mcause_wd,
    output logic        o_mie,
    output logic        o_mpie,
    output logic [31:0] o_mepc,
    output logic [31:0] o_mtval,
    output mcause_t     o_mcause,
    output logic        o_stall,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc
);

    trap_state_t r_state;
    trap_state_t w_next_state;

    ev_kind_t    r_kind;
    mcause_t     r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_tval;

    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mepc;
    logic [31:0] r_mtval;
    mcause_t     r_mcause;
    logic [31:0] r_redirect_pc;

    logic        w_irq_pend;
    mcause_t     w_irq_cause;
    logic        w_idle;
    logic        w_commit;
    logic        w_take_exc;
    logic        w_take_mret;
    logic        w_take_irq;
    logic        w_event;
    logic        w_csr_wr;
    logic [31:0] w_trap_target;

    irq_arb u_irq_arb (
        .i_mie       (r_mie),
        .i_mtip      (i_mtip),
        .i_msip      (i_msip),
        .i_meip      (i_meip),
        .i_mtie      (i_mtie),
        .i_msie      (i_msie),
        .i_meie      (i_meie),
        .o_irq_pend  (w_irq_pend),
        .o_irq_cause (w_irq_cause)
    );

    // A CSR write wins over a bare interrupt so the new mie is honoured next cycle.
    assign w_take_exc  = w_idle & i_exc_valid;
    assign w_take_mret = w_idle & ~i_exc_valid & i_mret;
    assign w_take_irq  = w_idle & ~i_exc_valid & ~i_mret & w_irq_pend & ~i_csr_we;
    assign w_event     = w_take_exc | w_take_mret | w_take_irq;
    assign w_csr_wr    = w_idle & i_csr_we & ~i_exc_valid & ~i_mret;

`ifdef TRAP_CTRL_VECTORED_EN
    assign w_trap_target = {i_mtvec_base, 2'b00} + vec_offset(r_cause);
`else
    assign w_trap_target = {i_mtvec_base, 2'b00};
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (w_event) w_next_state = ST_DRAIN;
            ST_DRAIN:    if (i_pipe_idle) w_next_state = ST_COMMIT;
            ST_COMMIT:   w_next_state = ST_REDIRECT;
            ST_REDIRECT: w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_idle           = (r_state == ST_IDLE);
        w_commit         = (r_state == ST_COMMIT);
        o_stall          = (r_state != ST_IDLE);
        o_redirect_valid = (r_state == ST_REDIRECT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_kind  <= EV_TRAP;
            r_cause <= MCAUSE_NONE;
            r_epc   <= 32'd0;
            r_tval  <= 32'd0;
        end else if (w_take_exc) begin
            r_kind  <= EV_TRAP;
            r_cause <= i_exc_cause;
            r_epc   <= i_exc_pc & ~32'd3;
            r_tval  <= i_exc_tval;
        end else if (w_take_mret) begin
            r_kind  <= EV_MRET;
        end else if (w_take_irq) begin
            r_kind  <= EV_TRAP;
            r_cause <= w_irq_cause;
            r_epc   <= i_retire_pc & ~32'd3;
            r_tval  <= 32'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mepc   <= 32'd0;
            r_mtval  <= 32'd0;
            r_mcause <= MCAUSE_NONE;
        end else if (w_csr_wr) begin
            r_mie    <= i_mie_wd;
            r_mpie   <= i_mpie_wd;
            r_mepc   <= i_mepc_wd;
            r_mtval  <= i_mtval_wd;
            r_mcause <= i_mcause_wd;
        end else if (w_commit) begin
            if (r_kind == EV_MRET) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else begin
                r_mepc   <= r_epc;
                r_mcause <= r_cause;
                r_mtval  <= r_tval;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end
        end
    end

    // Target captured at commit; mret reads mepc before any commit could touch it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_redirect_pc <= 32'd0;
        else if (w_commit) r_redirect_pc <= (r_kind == EV_MRET) ? r_mepc : w_trap_target;
    end

    assign o_mie         = r_mie;
    assign o_mpie        = r_mpie;
    assign o_mepc        = r_mepc;
    assign o_mtval       = r_mtval;
    assign o_mcause      = r_mcause;
    assign o_redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed plus randomized checks of trap_ctrl against an architectural trap model.
// Honours TRAP_CTRL_VECTORED_EN when computing interrupt targets.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_valid, mret, pipe_idle, csr_we;
    mcause_t     exc_cause, mcause_wd, mcause;
    logic [31:0] exc_pc, exc_tval, retire_pc, mepc_wd, mtval_wd;
    logic        mtip, msip, meip, mtie, msie, meie;
    logic [29:0] mtvec_base;
    logic        mie_wd, mpie_wd;
    logic        mie, mpie, stall, redirect_valid;
    logic [31:0] mepc, mtval, redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    logic        m_mie, m_mpie;
    logic [31:0] m_mepc, m_mcause, m_mtval;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_exc_valid(exc_valid), .i_exc_cause(exc_cause), .i_exc_pc(exc_pc), .i_exc_tval(exc_tval),
        .i_mret(mret), .i_retire_pc(retire_pc), .i_pipe_idle(pipe_idle),
        .i_mtip(mtip), .i_msip(msip), .i_meip(meip), .i_mtie(mtie), .i_msie(msie), .i_meie(meie),
        .i_mtvec_base(mtvec_base), .i_csr_we(csr_we),
        .i_mie_wd(mie_wd), .i_mpie_wd(mpie_wd), .i_mepc_wd(mepc_wd), .i_mtval_wd(mtval_wd),
        .i_mcause_wd(mcause_wd),
        .o_mie(mie), .o_mpie(mpie), .o_mepc(mepc), .o_mtval(mtval), .o_mcause(mcause),
        .o_stall(stall), .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_csrs(input string tag);
        chk({tag, "_mie"},    {31'd0, mie},  {31'd0, m_mie});
        chk({tag, "_mpie"},   {31'd0, mpie}, {31'd0, m_mpie});
        chk({tag, "_mepc"},   mepc,          m_mepc);
        chk({tag, "_mcause"}, mcause,        m_mcause);
        chk({tag, "_mtval"},  mtval,         m_mtval);
    endtask

    task automatic clear_inputs();
        exc_valid = 1'b0; mret = 1'b0; csr_we = 1'b0;
        mtip = 1'b0; msip = 1'b0; meip = 1'b0;
    endtask

    // Highest-priority enabled interrupt as an architectural mcause value, 0 if none.
    function automatic logic [31:0] model_irq();
        if (!m_mie)          return 32'd0;
        if (meip && meie)    return 32'h8000_000B;
        if (msip && msie)    return 32'h8000_0003;
        if (mtip && mtie)    return 32'h8000_0007;
        return 32'd0;
    endfunction

    task automatic noise();
        exc_valid = 1'($urandom); mret = 1'($urandom); csr_we = 1'($urandom);
        exc_cause = $urandom; exc_pc = $urandom; exc_tval = $urandom; retire_pc = $urandom;
        mtip = 1'($urandom); msip = 1'($urandom); meip = 1'($urandom);
        mie_wd = 1'($urandom); mpie_wd = 1'($urandom);
        mepc_wd = $urandom; mtval_wd = $urandom; mcause_wd = $urandom;
    endtask

    // One IDLE-cycle decision with the inputs as currently driven, then the full sequence if taken.
    task automatic step(input string tag, input int drain);
        logic        taken, is_mret;
        logic [31:0] cause, epc, tval, tgt, ic;
        ic = model_irq();
        taken = 1'b1; is_mret = 1'b0;
        cause = 32'd0; epc = 32'd0; tval = 32'd0;
        if (exc_valid) begin
            cause = exc_cause; epc = {exc_pc[31:2], 2'b00}; tval = exc_tval;
        end else if (mret) begin
            is_mret = 1'b1;
        end else if (ic != 32'd0 && !csr_we) begin
            cause = ic; epc = {retire_pc[31:2], 2'b00}; tval = 32'd0;
        end else begin
            taken = 1'b0;
        end
        if (!taken && csr_we) begin
            m_mie = mie_wd; m_mpie = mpie_wd; m_mepc = mepc_wd;
            m_mcause = mcause_wd; m_mtval = mtval_wd;
        end
        tick();
        exc_valid = 1'b0; mret = 1'b0; csr_we = 1'b0;
        if (!taken) begin
            chk({tag, "_nostall"}, {31'd0, stall}, 32'd0);
            chk({tag, "_norv"}, {31'd0, redirect_valid}, 32'd0);
            chk_csrs(tag);
            return;
        end
        chk({tag, "_stall0"}, {31'd0, stall}, 32'd1);
        for (int k = 0; k < drain; k++) begin
            noise();
            pipe_idle = 1'b0;
            tick();
            chk({tag, "_drain_stall"}, {31'd0, stall}, 32'd1);
            chk({tag, "_drain_rv"}, {31'd0, redirect_valid}, 32'd0);
        end
        noise();
        pipe_idle = 1'b1;
        tick();
        chk({tag, "_commit_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, "_commit_rv"}, {31'd0, redirect_valid}, 32'd0);
        if (is_mret) begin
            tgt = m_mepc;
            m_mie = m_mpie; m_mpie = 1'b1;
        end else begin
            tgt = {mtvec_base, 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
            if (cause[31]) tgt = tgt + 32'(cause[29:0]) * 32'd4;
`endif
            m_mpie = m_mie; m_mie = 1'b0;
            m_mepc = epc; m_mcause = cause; m_mtval = tval;
        end
        clear_inputs();
        tick();
        chk({tag, "_rv"}, {31'd0, redirect_valid}, 32'd1);
        chk({tag, "_rpc"}, redirect_pc, tgt);
        chk_csrs(tag);
        tick();
        chk({tag, "_rv_end"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, "_stall_end"}, {31'd0, stall}, 32'd0);
    endtask

    task automatic csr_write(input logic ie, input logic pie, input logic [31:0] epc,
                             input logic [31:0] cause, input logic [31:0] tv);
        csr_we = 1'b1; mie_wd = ie; mpie_wd = pie; mepc_wd = epc; mcause_wd = cause; mtval_wd = tv;
        step("csrw", 0);
    endtask

    initial begin
        rst_n = 1'b0; pipe_idle = 1'b1;
        clear_inputs();
        exc_cause = '0; exc_pc = '0; exc_tval = '0; retire_pc = '0;
        mtie = 1'b1; msie = 1'b1; meie = 1'b1; mtvec_base = 30'h40;
        mie_wd = 1'b0; mpie_wd = 1'b0; mepc_wd = '0; mtval_wd = '0; mcause_wd = '0;
        m_mie = 1'b0; m_mpie = 1'b0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
        #23;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk_csrs("rst");
        rst_n = 1'b1;
        tick();

        // Illegal instruction into base vector.
        csr_write(1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
        exc_valid = 1'b1; exc_cause = MCAUSE_ILLEGAL_INSTR; exc_pc = 32'h104; exc_tval = 32'hDEAD;
        step("illegal", 0);
        chk("ill_mepc_abs", mepc, 32'h104);
        chk("ill_mtval_abs", mtval, 32'hDEAD);
        chk("ill_mpie_abs", {31'd0, mpie}, 32'd1);

        // Simultaneous MEI and MTI: MEI wins.
        csr_write(1'b1, 1'b0, 32'd0, 32'd0, 32'h1234);
        meip = 1'b1; mtip = 1'b1; retire_pc = 32'h0000_0333;
        step("mei", 0);
        chk("mei_cause_abs", mcause, 32'h8000_000B);
        chk("mei_tval_abs", mtval, 32'd0);
        chk("mei_epc_abs", mepc, 32'h0000_0330);

        // MRET back to 0x200.
        csr_write(1'b0, 1'b1, 32'h200, 32'd0, 32'd0);
        mret = 1'b1;
        step("mret", 0);
        chk("mret_mie_abs", {31'd0, mie}, 32'd1);

        // Long drain.
        exc_valid = 1'b1; exc_cause = MCAUSE_ILLEGAL_INSTR; exc_pc = 32'h88; exc_tval = 32'h5;
        step("drain10", 10);

        // CSR write clearing mie beats a pending MTI, and MTI stays blocked afterwards.
        csr_write(1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
        mtip = 1'b1; csr_we = 1'b1; mie_wd = 1'b0; mpie_wd = 1'b1;
        mepc_wd = 32'h44; mtval_wd = 32'h55; mcause_wd = 32'h7;
        step("csr_vs_irq", 0);
        step("irq_blocked", 0);
        mtip = 1'b0;

        // CSR write alongside an exception is dropped.
        csr_write(1'b1, 1'b1, 32'h10, 32'd0, 32'd0);
        exc_valid = 1'b1; exc_cause = 32'd5; exc_pc = 32'h700; exc_tval = 32'h9;
        csr_we = 1'b1; mie_wd = 1'b0; mepc_wd = 32'hFFFF_FFF0; mtval_wd = 32'h77; mcause_wd = 32'h3;
        step("csr_vs_exc", 1);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            mtie = 1'($urandom); msie = 1'($urandom); meie = 1'($urandom);
            mtvec_base = $urandom;
            mtip = 1'($urandom); msip = 1'($urandom); meip = 1'($urandom);
            exc_valid = ($urandom_range(0, 3) == 0);
            mret = ($urandom_range(0, 3) == 0);
            csr_we = ($urandom_range(0, 2) == 0);
            exc_cause = {1'b0, 31'($urandom_range(0, 15))};
            exc_pc = $urandom; exc_tval = $urandom; retire_pc = $urandom;
            mie_wd = 1'($urandom); mpie_wd = 1'($urandom);
            mepc_wd = $urandom; mtval_wd = $urandom; mcause_wd = $urandom;
            step("rand", $urandom_range(0, 3));
        end

        // Reset in the middle of a drain abandons the trap.
        mtvec_base = 30'h40;
        csr_write(1'b1, 1'b1, 32'h123, 32'h2, 32'h456);
        exc_valid = 1'b1; exc_cause = MCAUSE_ILLEGAL_INSTR; exc_pc = 32'h900; exc_tval = 32'h1;
        pipe_idle = 1'b0;
        tick();
        exc_valid = 1'b0;
        tick();
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        m_mie = 1'b0; m_mpie = 1'b0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("mid_rst_rpc", redirect_pc, 32'd0);
        chk_csrs("mid_rst");
        tick();
        rst_n = 1'b1; pipe_idle = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_rv", {31'd0, redirect_valid}, 32'd0);
            chk("post_rst_stall", {31'd0, stall}, 32'd0);
        end
        chk_csrs("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameters: none; the block SHALL be fully specified by ports and one macro.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 exc_valid  in  1  retiring instruction raised a synchronous exception.
REQ-005 exc_cause  in  mcause_t  exception cause code.
REQ-006 exc_pc / exc_tval  in  32 each  faulting instruction address and trap value.
REQ-007 mret  in  1  retiring instruction is MRET.
REQ-008 retire_pc  in  32  address of next instruction to execute (interrupt return point).
REQ-009 pipe_idle  in  1  pipeline drained, no instruction in flight.
REQ-010 mtip, msip, meip  in  1 each  interrupt pending lines.
REQ-011 mtie, msie, meie  in  1 each  interrupt enables.
REQ-012 mtvec_base  in  30  trap vector base [31:2].
REQ-013 csr_we  in  1  apply CSR-instruction write-back values this cycle.
REQ-014 mie_wd, mpie_wd  in  1 each; mepc_wd, mtval_wd  in  32 each; mcause_wd  in  mcause_t  CSR write-back values.
REQ-015 mie, mpie  out  1 each; mepc, mtval  out  32 each; mcause  out  mcause_t  architectural trap state.
REQ-016 stall  out  1  freeze fetch/issue while trap sequencing is in progress.
REQ-017 redirect_valid  out  1  one-cycle PC redirect strobe; redirect_pc  out  32  target.

Function
REQ-018 FSM states: IDLE, DRAIN, COMMIT, REDIRECT; stall SHALL be 1 in every state except IDLE.
REQ-019 irq_pend SHALL be mie & ((meip&meie)|(msip&msie)|(mtip&mtie)); priority MEI > MSI > MTI.
REQ-020 In IDLE, event priority SHALL be exc_valid > mret > irq_pend; the winning event is latched (kind, cause, pc, tval) and the FSM moves to DRAIN next edge.
REQ-021 Exception latch: cause=exc_cause, epc={exc_pc[31:2],2'b00}, tval=exc_tval; interrupt latch: cause=MCAUSE_MEI/MSI/MTI, epc=retire_pc with [1:0] cleared, tval=0.
REQ-022 DRAIN SHALL hold until pipe_idle=1, then go to COMMIT; no timeout.
REQ-023 COMMIT (trap): mepc<=epc, mcause<=cause, mtval<=tval, mpie<=mie, mie<=0; COMMIT (mret): mie<=mpie, mpie<=1; then go to REDIRECT.
REQ-024 REDIRECT: redirect_valid=1 for exactly one cycle, redirect_pc = {mtvec_base,2'b00} for traps, mepc for mret; then go to IDLE.
REQ-025 Minimum latency: event sampled at edge N with pipe_idle=1 -> redirect_valid high in the cycle after edge N+2.
REQ-026 csr_we in IDLE with no event: all five CSR fields loaded from *_wd on that edge.
REQ-027 csr_we with exc_valid or mret in the same cycle: the write SHALL be discarded.
REQ-028 csr_we with only irq_pend: the write SHALL be applied and the interrupt SHALL NOT be taken that cycle; it is re-evaluated next cycle against the new mie.
REQ-029 csr_we outside IDLE SHALL be ignored; events arriving outside IDLE SHALL be ignored (the source holds them).
REQ-030 Pending lines changing during DRAIN/COMMIT SHALL NOT alter the latched cause.

Reset
REQ-031 On rst_n=0: state=IDLE, mie=0, mpie=0, mepc=0, mcause=0, mtval=0, stall=0, redirect_valid=0, redirect_pc=0.
REQ-032 Reset asserted mid-sequence SHALL abandon it with no redirect and no partial CSR commit.

Configuration
REQ-033 Macro TRAP_CTRL_VECTORED_EN defined: interrupt redirect_pc = {mtvec_base,2'b00} + 4*cause code (MSI 0x0C, MTI 0x1C, MEI 0x2C offsets); exceptions still use base.
REQ-034 Macro undefined: direct mode only; all traps redirect to {mtvec_base,2'b00}.

Structure
REQ-035 trap_state_t (FSM encoding) SHALL live in the shared enums package beside mcause_t; no new constants outside it.
REQ-036 One combinational sub-module irq_arb SHALL compute irq_pend and the selected interrupt cause.

Verification
REQ-037 Reset mid-DRAIN: exc_valid, hold pipe_idle=0, pulse rst_n low -> all outputs 0, no redirect_valid.
REQ-038 Illegal instr: exc_valid, cause=ILLEGAL_INSTR, exc_pc=0x104, tval=0xDEAD, mie=1, mtvec_base=0x40 -> mepc=0x104, mtval=0xDEAD, mie=0, mpie=1, redirect_pc=0x100 three cycles later.
REQ-039 Simultaneous meip+mtip, all enables=1, mie=1 -> mcause=MEI, mtval=0; with TRAP_CTRL_VECTORED_EN, redirect_pc=0x12C.
REQ-040 mret with mepc=0x200, mpie=1 -> mie=1, mpie=1, redirect_pc=0x200 single-cycle strobe.
REQ-041 Hold pipe_idle=0 for 10 cycles after exc_valid -> stall=1 throughout, redirect_valid after pipe_idle rises + 2 edges.
REQ-042 csr_we with mie_wd=0 while mtip pending -> write applied, no trap taken next cycle.
